imem_program_loader: RTL

//  Byte-stream program loader for the sequential RV64 subset CPU. Assembles little-endian

---
 rtl/cpu_pkg.sv | 19 +
 rtl/loader_word_assembler.sv | 38 +++
 rtl/imem_program_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the program loader.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } loader_state_t;

    // The loader and the CPU agree on one end-of-program word.
    function automatic logic is_halt(input logic [INSTR_W-1:0] w);
        return w == HALT_INSTR;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler with a running XOR of accepted bytes.
// word/word_valid are combinational on the cycle the fourth byte is accepted.
module loader_word_assembler
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               byte_fire,
    input  logic [7:0]         byte_in,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word,
    output logic [7:0]         xor_sum
);

    logic [1:0]          byte_idx;
    logic [INSTR_W-9:0]  shreg;

    // Shift bytes in from the top so byte 0 ends up in the lowest lane.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx <= '0;
            shreg    <= '0;
            xor_sum  <= '0;
        end else if (byte_fire) begin
            byte_idx <= byte_idx + 2'd1;
            shreg    <= {byte_in, shreg[INSTR_W-9:8]};
            xor_sum  <= xor_sum ^ byte_in;
        end
    end

    // Completed word: current byte is lane 3, the three held bytes fill lanes 2..0.
    always_comb begin
        word_valid = byte_fire && (byte_idx == 2'd3);
        word       = {byte_in, shreg};
    end

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles bytes into instructions, writes imem
// from word 0 upward and holds the CPU in reset until the load finishes.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(IMEM_DEPTH - 1);

    loader_state_t      state_q, state_d;
    logic               fire;
    logic               asm_fire;
    logic               start_ok;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic [7:0]         xor_sum;

`ifdef LOADER_CHECKSUM_EN
    logic               chk_bad;
`else
    logic               unused_xor;
    assign unused_xor = ^xor_sum;
`endif

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_fire  (asm_fire),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word),
        .xor_sum    (xor_sum)
    );

    // Handshake and qualified events.
    always_comb begin
        in_ready = (state_q == LOAD) || (state_q == CHECK);
        fire     = in_valid && in_ready;
        asm_fire = fire && (state_q == LOAD);
        start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; LOAD exits on the edge that completes the final word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (word_valid) begin
                    if (is_halt(word)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if (word_count == LAST_SLOT) begin
                        state_d = DONE;
                    end
                end
            end
            CHECK: begin
                if (fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port, word counter and status outputs.
    // done/cpu_reset follow DONE by one edge so the CPU only sees a fully written imem.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_bad    <= 1'b0;
`endif
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_wdata <= word;
                imem_addr  <= word_count[ADDR_W-1:0];
                word_count <= word_count + CNT_W'(1);
                if (!is_halt(word) && (word_count == LAST_SLOT)) begin
                    error <= 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            if ((state_q == CHECK) && fire) begin
                error   <= (in_data != xor_sum);
                chk_bad <= (in_data != xor_sum);
            end
`endif
            if (start_ok) begin
                done       <= 1'b0;
                cpu_reset  <= 1'b1;
                error      <= 1'b0;
                word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk_bad    <= 1'b0;
`endif
            end else if (state_q == DONE) begin
                done <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                cpu_reset <= chk_bad;
`else
                cpu_reset <= 1'b0;
`endif
            end
        end
    end

endmodule
